// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared constants and types for the
// data-memory load/store controller.
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/half lane extract + extend, store merge,
// and misalign/illegal decode for RV32I loads and stores.
module lsu_align
  import dmem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] word,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    err    = 1'b0;
    rdata  = '0;
    merged = word;
    unique case (funct3)
      F3_B: begin
        rdata = {{(XLEN-8){lane_b[7]}}, lane_b};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        rdata = {{(XLEN-16){lane_h[15]}}, lane_h};
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
        err = off[0];
      end
      F3_W: begin
        rdata  = word;
        merged = wdata;
        err    = |off;
      end
      F3_BU: begin
        rdata = {{(XLEN-8){1'b0}}, lane_b};
        err   = we;
      end
      F3_HU: begin
        rdata = {{(XLEN-16){1'b0}}, lane_h};
        err   = we | off[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store sequencer in front of a word-only
// single-port data memory, with read-modify-write for SB/SH.
module dmem_lsu_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_dataW,
  output logic            mem_MemRW,
  input  logic [XLEN-1:0] mem_dataB
);

  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_dataW_q, mem_dataW_d;
  logic            mem_MemRW_q, mem_MemRW_d;

  logic            idle;
  logic            al_we;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [XLEN-1:0] al_wdata;
  logic            al_err;
  logic [XLEN-1:0] al_rdata;
  logic [XLEN-1:0] al_merged;

  // Decode the live request in IDLE, the latched one afterwards.
  assign idle     = (state_q == IDLE);
  assign al_we    = idle ? req_we : we_q;
  assign al_f3    = idle ? req_funct3 : f3_q;
  assign al_off   = idle ? req_addr[1:0] : off_q;
  assign al_wdata = idle ? req_wdata : wdata_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .we     (al_we),
    .funct3 (al_f3),
    .off    (al_off),
    .wdata  (al_wdata),
    .word   (mem_dataB),
    .err    (al_err),
    .rdata  (al_rdata),
    .merged (al_merged)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_dataW_d  = mem_dataW_q;
    mem_MemRW_d  = mem_MemRW_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if (al_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && req_funct3 == F3_W) begin
            state_d     = WRITE;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_dataW_d = req_wdata;
            mem_MemRW_d = MEM_WRITE;
          end else begin
            state_d     = READ;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_MemRW_d = MEM_READ;
            cnt_d       = LAT_M1;
          end
        end
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          if (we_q) begin
            state_d     = WRITE;
            mem_dataW_d = al_merged;
            mem_MemRW_d = MEM_WRITE;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = al_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        state_d      = RESP;
        mem_MemRW_d  = MEM_READ;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_dataW_q  <= '0;
      mem_MemRW_q  <= MEM_READ;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_dataW_q  <= mem_dataW_d;
      mem_MemRW_q  <= mem_MemRW_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_dataW  = mem_dataW_q;
  assign mem_MemRW  = mem_MemRW_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: scoreboard bench for the load/store
// controller, with a small word memory model.
module tb_dmem_lsu_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_dataW, mem_dataB;
  logic        mem_MemRW;

  logic        l3_req_valid, l3_req_ready;
  logic        l3_resp_valid, l3_resp_err;
  logic [31:0] l3_resp_rdata;
  logic [31:0] l3_mem_addr, l3_mem_dataW, l3_mem_dataB;
  logic        l3_mem_MemRW;

  dmem_lsu_ctrl #(.XLEN(32), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW),
    .mem_MemRW(mem_MemRW), .mem_dataB(mem_dataB)
  );

  dmem_lsu_ctrl #(.XLEN(32), .READ_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_we(1'b0), .req_funct3(3'd2),
    .req_addr(32'h10), .req_wdata(32'h0),
    .resp_valid(l3_resp_valid), .resp_ready(1'b1),
    .resp_rdata(l3_resp_rdata), .resp_err(l3_resp_err),
    .mem_addr(l3_mem_addr), .mem_dataW(l3_mem_dataW),
    .mem_MemRW(l3_mem_MemRW), .mem_dataB(l3_mem_dataB)
  );

  assign l3_mem_dataB = (l3_mem_addr == 32'h10) ? 32'h80007F01 : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:15];
  int          wr_cnt = 0;
  int          consec = 0;
  int          bad_addr = 0;
  logic        prev_rw = 1'b0;
  logic [31:0] last_wd = 32'h0;

  assign mem_dataB = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h80007F01;
    end else if (mem_MemRW) begin
      mem[mem_addr[5:2]] <= mem_dataW;
      wr_cnt  <= wr_cnt + 1;
      last_wd <= mem_dataW;
      if (prev_rw) consec <= consec + 1;
      if (mem_addr[1:0] != 2'b00 || mem_addr >= 32'd64)
        bad_addr <= bad_addr + 1;
    end
    prev_rw <= mem_MemRW;
  end

  exp_t sb_q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic issue(input logic t_we, input logic [2:0] t_f3,
                       input logic [31:0] t_addr, input logic [31:0] t_wd,
                       output int t_acc);
    int n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = t_we;
    req_funct3 = t_f3;
    req_addr   = t_addr;
    req_wdata  = t_wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 t_acc = cyc;
  endtask

  task automatic wait_resp(input int t_acc, input int hold,
                           input logic drop, input int w0, input int ew);
    exp_t e;
    int   n = 0;
    do begin
      @(negedge clk);
      if (drop) req_valid = 1'b0;
      n++;
    end while (!resp_valid && n < 40);
    e = sb_q.pop_front();
    if (!resp_valid) begin
      chk("resp_timeout", 32'd0, 32'd1);
      resp_ready = 1'b1;
      return;
    end
    chk("rdata", resp_rdata, e.rdata);
    chk("err", {31'b0, resp_err}, {31'b0, e.err});
    chk("latency", cyc - t_acc + 1, e.lat);
    chk("writes", wr_cnt - w0, ew);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, e.rdata);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 chk("resp_drop", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic run(input logic t_we, input logic [2:0] t_f3,
                     input logic [31:0] t_addr, input logic [31:0] t_wd,
                     input logic [31:0] er, input logic ee,
                     input int el, input int ew);
    int w0;
    int acc;
    w0 = wr_cnt;
    sb_q.push_back('{rdata: er, err: ee, lat: el});
    issue(t_we, t_f3, t_addr, t_wd, acc);
    wait_resp(acc, 0, 1'b1, w0, ew);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_dataW"}, mem_dataW, 32'd0);
    chk({tag, "_mem_MemRW"}, {31'b0, mem_MemRW}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, w0, n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    resp_ready = 1'b1;
    l3_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    // loads of 0x80007F01 at 0x10
    run(0, 3'd0, 32'h13, 0, 32'hFFFFFF80, 0, 2, 0);
    run(0, 3'd4, 32'h13, 0, 32'h00000080, 0, 2, 0);
    run(0, 3'd1, 32'h12, 0, 32'hFFFF8000, 0, 2, 0);
    run(0, 3'd5, 32'h10, 0, 32'h00007F01, 0, 2, 0);
    run(0, 3'd2, 32'h10, 0, 32'h80007F01, 0, 2, 0);

    // sub-word and word stores
    run(1, 3'd0, 32'h11, 32'h123456AA, 32'h0, 0, 3, 1);
    chk("sb_dataW", last_wd, 32'h8000AA01);
    run(0, 3'd2, 32'h10, 0, 32'h8000AA01, 0, 2, 0);
    run(1, 3'd1, 32'h12, 32'h0000BEEF, 32'h0, 0, 3, 1);
    run(1, 3'd2, 32'h14, 32'hCAFEF00D, 32'h0, 0, 2, 1);
    chk("mem_10", mem[4], 32'hBEEFAA01);
    chk("mem_14", mem[5], 32'hCAFEF00D);

    // errors: no memory access
    run(0, 3'd2, 32'h12, 0, 32'h0, 1, 1, 0);
    run(1, 3'd1, 32'h11, 32'hFFFF, 32'h0, 1, 1, 0);
    run(0, 3'd3, 32'h10, 0, 32'h0, 1, 1, 0);
    run(1, 3'd4, 32'h10, 32'hFF, 32'h0, 1, 1, 0);
    chk("err_mem_10", mem[4], 32'hBEEFAA01);
    chk("err_mem_14", mem[5], 32'hCAFEF00D);

    // stalled response with a second request held
    w0 = wr_cnt;
    resp_ready = 1'b0;
    sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, lat: 2});
    issue(0, 3'd2, 32'h14, 0, acc);
    req_addr = 32'h10;
    sb_q.push_back('{rdata: 32'hBEEFAA01, err: 1'b0, lat: 2});
    wait_resp(acc, 5, 1'b0, w0, 0);
    @(negedge clk);
    chk("stall_idle_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 acc2 = cyc;
    chk("stall_accept2", {31'b0, req_ready}, 32'd0);
    wait_resp(acc2, 0, 1'b1, w0, 0);

    // reset during the READ of an SB
    w0 = wr_cnt;
    issue(1, 3'd0, 32'h10, 32'h000000FF, acc);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outs("rst_read");
    repeat (3) @(negedge clk);
    chk("rst_read_writes", wr_cnt - w0, 32'd0);
    chk("rst_read_mem", mem[4], 32'hBEEFAA01);

    // reset during the WRITE of an SH
    w0 = wr_cnt;
    issue(1, 3'd1, 32'h10, 32'h00001234, acc);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wr_memrw", {31'b0, mem_MemRW}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outs("rst_write");
    chk("rst_wr_writes", wr_cnt - w0, 32'd1);
    chk("rst_wr_mem", mem[4], 32'hBEEF1234);
    run(0, 3'd2, 32'h10, 0, 32'hBEEF1234, 0, 2, 0);

    // READ_LAT=3 instance
    sb_q.push_back('{rdata: 32'h80007F01, err: 1'b0, lat: 4});
    @(negedge clk);
    chk("l3_req_ready", {31'b0, l3_req_ready}, 32'd1);
    l3_req_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      l3_req_valid = 1'b0;
      n++;
    end while (!l3_resp_valid && n < 40);
    begin
      exp_t e;
      e = sb_q.pop_front();
      chk("l3_valid", {31'b0, l3_resp_valid}, 32'd1);
      chk("l3_rdata", l3_resp_rdata, e.rdata);
      chk("l3_err", {31'b0, l3_resp_err}, {31'b0, e.err});
      chk("l3_latency", cyc - acc + 1, e.lat);
    end
    repeat (2) @(negedge clk);

    chk("memrw_consecutive", consec, 32'd0);
    chk("mem_addr_align", bad_addr, 32'd0);
    chk("l3_memrw", {31'b0, l3_mem_MemRW}, 32'd0);
    chk("l3_dataW", l3_mem_dataW, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
